alu_seq: RTL and testbench

//  Parametrised, registered ALU: the successor to the 8-bit combinational ALU.
//  - Adds logic ops, shifts, carry-chained add/sub and an iterative multiply.
//  - Adds a persistent flag register and valid/ready handshakes on input and output.
//  - Sits between the decode/register-file stage and writeback.
//  - One operation is in flight at a time; the unit stalls the pipeline through in_ready.

---
 rtl/alu_seq.sv | 270 +++++++++++++++++++++++++++
 tb/tb_alu_seq.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// alu_seq
//   Registered, parametrised ALU sitting between decode/register-file and
//   writeback. One operation is in flight at a time; the unit stalls the
//   pipeline through in_ready. Single-cycle ops are computed at accept and
//   registered. MUL runs an iterative shift-add for WIDTH cycles.
//
// Ports
//   clk        in   rising-edge system clock
//   rst        in   asynchronous, active-high reset
//   in_valid   in   op/a/b valid; transfer on in_valid & in_ready
//   in_ready   out  unit can accept (IDLE, or DONE while out_ready is high)
//   op         in   4-bit opcode
//   a, b       in   operands; shifts use b[SHW-1:0] as the amount
//   out_valid  out  result/result_hi/flags valid (state DONE)
//   out_ready  in   consumer takes the result; transfer on out_valid & out_ready
//   result     out  result; low half of the product for MUL
//   result_hi  out  high half of the product for MUL, otherwise 0
//   flags      out  {N,V,C,Z} flag register
//   busy       out  high while a multiply is iterating
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic [3:0]       flags,
  output logic             busy
);

  localparam int SHW = $clog2(WIDTH);
  localparam int MSB = WIDTH - 1;
  localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);
  localparam logic [WIDTH:0] ONE_EXT  = (WIDTH + 1)'(1);

  typedef enum logic [3:0] {
    OP_ADD   = 4'd0,
    OP_SUB   = 4'd1,
    OP_INC   = 4'd2,
    OP_DEC   = 4'd3,
    OP_AND   = 4'd4,
    OP_OR    = 4'd5,
    OP_XOR   = 4'd6,
    OP_NOT   = 4'd7,
    OP_SHL   = 4'd8,
    OP_SHR   = 4'd9,
    OP_SAR   = 4'd10,
    OP_ADC   = 4'd11,
    OP_SBB   = 4'd12,
    OP_MUL   = 4'd13,
    OP_CMP   = 4'd14,
    OP_PASSB = 4'd15
  } opcode_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     result_q, result_d;
  logic [WIDTH-1:0]     resultHi_q, resultHi_d;
  logic [3:0]           flags_q, flags_d;
  logic [WIDTH-1:0]     mcand_q, mcand_d;
  logic [2*WIDTH-1:0]   prod_q, prod_d;
  logic [SHW-1:0]       cnt_q, cnt_d;

  logic [WIDTH-1:0]     aluRes;
  logic [WIDTH-1:0]     flagSrc;
  logic [WIDTH:0]       ext;
  logic signed [WIDTH:0] sarExt;
  logic                 aluC;
  logic                 aluV;
  logic [3:0]           aluFlags;
  logic                 carryIn;
  logic [SHW-1:0]       shAmt;

  logic [WIDTH:0]       mulSum;
  logic [2*WIDTH-1:0]   mulNext;
  logic                 issue;

  // ADC/SBB chain off the C flag of the previously completed op.
  assign carryIn = flags_q[1];
  assign shAmt   = b[SHW-1:0];

  // Single-cycle datapath. Arithmetic is done one bit wider so the top bit
  // is the carry (add) or borrow (subtract). Shifts pad a guard bit on the
  // side bits leave from, so the guard ends up holding the last bit shifted
  // out and is naturally 0 for a zero shift amount.
  always_comb begin
    ext     = '0;
    sarExt  = '0;
    aluRes  = '0;
    aluC    = 1'b0;
    aluV    = 1'b0;
    flagSrc = '0;
    case (opcode_t'(op))
      OP_ADD: begin
        ext    = {1'b0, a} + {1'b0, b};
        aluRes = ext[MSB:0];
        aluC   = ext[WIDTH];
        aluV   = (a[MSB] == b[MSB]) && (aluRes[MSB] != a[MSB]);
      end
      OP_ADC: begin
        ext    = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, carryIn};
        aluRes = ext[MSB:0];
        aluC   = ext[WIDTH];
        aluV   = (a[MSB] == b[MSB]) && (aluRes[MSB] != a[MSB]);
      end
      OP_INC: begin
        ext    = {1'b0, a} + ONE_EXT;
        aluRes = ext[MSB:0];
        aluC   = ext[WIDTH];
        aluV   = !a[MSB] && aluRes[MSB];
      end
      OP_SUB, OP_CMP: begin
        ext    = {1'b0, a} - {1'b0, b};
        aluRes = ext[MSB:0];
        aluC   = ext[WIDTH];
        aluV   = (a[MSB] != b[MSB]) && (aluRes[MSB] != a[MSB]);
      end
      OP_SBB: begin
        ext    = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, carryIn};
        aluRes = ext[MSB:0];
        aluC   = ext[WIDTH];
        aluV   = (a[MSB] != b[MSB]) && (aluRes[MSB] != a[MSB]);
      end
      OP_DEC: begin
        ext    = {1'b0, a} - ONE_EXT;
        aluRes = ext[MSB:0];
        aluC   = ext[WIDTH];
        aluV   = a[MSB] && !aluRes[MSB];
      end
      OP_AND:   aluRes = a & b;
      OP_OR:    aluRes = a | b;
      OP_XOR:   aluRes = a ^ b;
      OP_NOT:   aluRes = ~a;
      OP_PASSB: aluRes = b;
      OP_SHL: begin
        ext    = {1'b0, a} << shAmt;
        aluRes = ext[MSB:0];
        aluC   = ext[WIDTH];
      end
      OP_SHR: begin
        ext    = {a, 1'b0} >> shAmt;
        aluRes = ext[WIDTH:1];
        aluC   = ext[0];
      end
      OP_SAR: begin
        sarExt = $signed({a, 1'b0}) >>> shAmt;
        aluRes = sarExt[WIDTH:1];
        aluC   = sarExt[0];
      end
      default: aluRes = '0;
    endcase
    // CMP reports A but sets N/Z from the difference, like SUB.
    flagSrc = aluRes;
    if (opcode_t'(op) == OP_CMP) begin
      aluRes = a;
    end
    aluFlags = {flagSrc[MSB], aluV, aluC, (flagSrc == '0)};
  end

  // One shift-add multiply step: the multiplier sits in the low half of
  // prod_q and is consumed LSB first while partial sums build up in the
  // high half; after WIDTH steps prod_q holds the full product.
  always_comb begin
    mulSum = {1'b0, prod_q[2*WIDTH-1:WIDTH]};
    if (prod_q[0]) begin
      mulSum = mulSum + {1'b0, mcand_q};
    end
    mulNext = {mulSum, prod_q[WIDTH-1:1]};
  end

  // Control: handshakes, next state and register updates. An accept can
  // happen from IDLE, or from DONE on the same edge the result is taken,
  // which gives one result per cycle for back-to-back single-cycle ops.
  always_comb begin
    state_d    = state_q;
    result_d   = result_q;
    resultHi_d = resultHi_q;
    flags_d    = flags_q;
    mcand_d    = mcand_q;
    prod_d     = prod_q;
    cnt_d      = cnt_q;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    issue      = 1'b0;
    case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        issue    = in_valid;
      end
      S_MUL: begin
        busy   = 1'b1;
        prod_d = mulNext;
        cnt_d  = cnt_q + SHW'(1);
        if (cnt_q == CNT_LAST) begin
          state_d    = S_DONE;
          result_d   = mulNext[MSB:0];
          resultHi_d = mulNext[2*WIDTH-1:WIDTH];
          flags_d    = {mulNext[MSB], 1'b0,
                        (mulNext[2*WIDTH-1:WIDTH] != '0),
                        (mulNext == '0)};
        end
      end
      S_DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) begin
          if (in_valid) begin
            issue = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (issue) begin
      if (opcode_t'(op) == OP_MUL) begin
        state_d = S_MUL;
        mcand_d = a;
        prod_d  = {{WIDTH{1'b0}}, b};
        cnt_d   = '0;
      end else begin
        state_d    = S_DONE;
        result_d   = aluRes;
        resultHi_d = '0;
        flags_d    = aluFlags;
      end
    end
  end

  // State and datapath registers; reset clears everything immediately,
  // aborting any multiply or pending result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      result_q   <= '0;
      resultHi_q <= '0;
      flags_q    <= '0;
      mcand_q    <= '0;
      prod_q     <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      result_q   <= result_d;
      resultHi_q <= resultHi_d;
      flags_q    <= flags_d;
      mcand_q    <= mcand_d;
      prod_q     <= prod_d;
      cnt_q      <= cnt_d;
    end
  end

  assign result    = result_q;
  assign result_hi = resultHi_q;
  assign flags     = flags_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq
//   Self-checking bench for alu_seq (WIDTH=8). Expected results come from a
//   behavioural integer model, are queued when an op is accepted and are
//   compared when the DUT hands a result over. Directed sections cover the
//   latency, stall, back-to-back and mid-operation reset behaviour.
module tb_alu_seq;

  localparam int WIDTH = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] op;
  logic [7:0] a;
  logic [7:0] b;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] result;
  logic [7:0] result_hi;
  logic [3:0] flags;
  logic       busy;

  typedef struct packed {
    logic [7:0] res;
    logic [7:0] hi;
    logic [3:0] flg;
  } exp_t;

  exp_t sbQ[$];
  exp_t monE;
  int   checks = 0;
  int   errors = 0;
  logic modelCarry = 1'b0;
  bit   randReady = 1'b0;

  logic [3:0] tblOp [0:9] = '{4'd2, 4'd3, 4'd11, 4'd14, 4'd4, 4'd5, 4'd6, 4'd7, 4'd15, 4'd1};
  logic [7:0] tblA  [0:9] = '{8'hFF, 8'h00, 8'h10, 8'h05, 8'hC3, 8'hC3, 8'hC3, 8'hC3, 8'h12, 8'h00};
  logic [7:0] tblB  [0:9] = '{8'h00, 8'h00, 8'h20, 8'h07, 8'h0F, 8'h0F, 8'h0F, 8'h0F, 8'hA5, 8'h01};

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .result_hi (result_hi),
    .flags     (flags),
    .busy      (busy)
  );

  // Single point of comparison: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at t=%0t",
               tag, observed, expected, $time);
    end
  endtask

  // Reference model built on plain integer arithmetic.
  function automatic exp_t modelOp(input logic [3:0] o, input logic [7:0] x,
                                   input logic [7:0] y, input logic cin);
    int ua, ub, sa, sb, full, sfull, n, ci;
    logic [7:0] r, hi, fsrc;
    logic c, v, z;
    exp_t e;
    ua = int'(x);
    ub = int'(y);
    sa = int'($signed(x));
    sb = int'($signed(y));
    n  = int'(y[2:0]);
    ci = cin ? 1 : 0;
    r = '0; hi = '0; c = 1'b0; v = 1'b0; full = 0; sfull = 0;
    case (o)
      4'd0, 4'd2, 4'd11: begin
        if (o == 4'd2) begin ub = 1; sb = 1; end
        if (o != 4'd11) ci = 0;
        full  = ua + ub + ci;
        sfull = sa + sb + ci;
        r = 8'(full);
        c = (full > 255);
        v = (sfull > 127) || (sfull < -128);
      end
      4'd1, 4'd3, 4'd12, 4'd14: begin
        if (o == 4'd3) begin ub = 1; sb = 1; end
        if (o != 4'd12) ci = 0;
        full  = ua - ub - ci;
        sfull = sa - sb - ci;
        r = 8'(full);
        c = (full < 0);
        v = (sfull > 127) || (sfull < -128);
      end
      4'd4:  r = x & y;
      4'd5:  r = x | y;
      4'd6:  r = x ^ y;
      4'd7:  r = ~x;
      4'd15: r = y;
      4'd8: begin
        full = ua << n;
        r = 8'(full);
        c = (n != 0) && (((ua >> (8 - n)) & 1) != 0);
      end
      4'd9: begin
        r = 8'(ua >> n);
        c = (n != 0) && (((ua >> (n - 1)) & 1) != 0);
      end
      4'd10: begin
        r = 8'(sa >>> n);
        c = (n != 0) && (((ua >> (n - 1)) & 1) != 0);
      end
      default: begin
        full = ua * ub;
        r  = 8'(full);
        hi = 8'(full >> 8);
        c  = (hi != 0);
      end
    endcase
    fsrc = r;
    if (o == 4'd14) r = x;
    z = (o == 4'd13) ? (full == 0) : (fsrc == 8'h00);
    e.res = r;
    e.hi  = hi;
    e.flg = {fsrc[7], v, c, z};
    return e;
  endfunction

  // Drives one op and holds it until accepted; queues the expected result.
  task automatic applyStimulus(input logic [3:0] o, input logic [7:0] x,
                               input logic [7:0] y, output int waits);
    bit rdy;
    exp_t e;
    waits = 0;
    rdy = 1'b0;
    op = o; a = x; b = y; in_valid = 1'b1;
    while (!rdy && waits < 200) begin
      if (randReady) out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      #1;
      if (!rdy) waits++;
    end
    checkOutput("accept", 32'(rdy), 32'd1);
    if (rdy) begin
      e = modelOp(o, x, y, modelCarry);
      sbQ.push_back(e);
      modelCarry = e.flg[1];
    end
    in_valid = 1'b0;
    op = 4'($urandom);
    a  = 8'($urandom);
    b  = 8'($urandom);
  endtask

  task automatic waitDrain();
    int n;
    n = 0;
    out_ready = 1'b1;
    while (sbQ.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    checkOutput("drain", 32'(sbQ.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  // Scoreboard side: compare on every output transfer.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      checkOutput("sb_nonempty", 32'(sbQ.size() != 0), 32'd1);
      if (sbQ.size() != 0) begin
        monE = sbQ.pop_front();
        checkOutput("sb_result", 32'(result), 32'(monE.res));
        checkOutput("sb_result_hi", 32'(result_hi), 32'(monE.hi));
        checkOutput("sb_flags", 32'(flags), 32'(monE.flg));
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int w;
    rst = 1'b1; in_valid = 1'b0; op = '0; a = '0; b = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_result", 32'(result), 32'd0);
    checkOutput("rst_result_hi", 32'(result_hi), 32'd0);
    checkOutput("rst_flags", 32'(flags), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // ADD FF+01: wraps to zero with carry, valid one cycle after accept.
    applyStimulus(4'd0, 8'hFF, 8'h01, w);
    @(negedge clk);
    checkOutput("add_valid", 32'(out_valid), 32'd1);
    checkOutput("add_result", 32'(result), 32'h00);
    checkOutput("add_flags", 32'(flags), 32'b0011);
    @(posedge clk);
    #1;

    // Overflowing SUB then SBB with C=0; ADD setting C then ADC consuming it.
    applyStimulus(4'd1, 8'h80, 8'h01, w);
    applyStimulus(4'd12, 8'h00, 8'h00, w);
    applyStimulus(4'd0, 8'hF0, 8'h20, w);
    applyStimulus(4'd11, 8'h01, 8'h01, w);
    @(negedge clk);
    checkOutput("adc_result", 32'(result), 32'h03);
    checkOutput("adc_flags", 32'(flags), 32'b0000);
    waitDrain();

    // MUL 200*3: stalled for 8 cycles, result valid on the 9th.
    applyStimulus(4'd13, 8'd200, 8'd3, w);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checkOutput("mul_busy", 32'(busy), 32'd1);
      checkOutput("mul_in_ready", 32'(in_ready), 32'd0);
      checkOutput("mul_out_valid_early", 32'(out_valid), 32'd0);
    end
    @(negedge clk);
    checkOutput("mul_out_valid", 32'(out_valid), 32'd1);
    checkOutput("mul_result", 32'(result), 32'h58);
    checkOutput("mul_result_hi", 32'(result_hi), 32'h02);
    checkOutput("mul_flags", 32'(flags), 32'b0010);
    @(posedge clk);
    #1;

    // Shifts: SAR 90>>3, SHL 81<<1, SHR by a zero amount (b=8 -> n=0).
    applyStimulus(4'd10, 8'h90, 8'h03, w);
    applyStimulus(4'd8, 8'h81, 8'h01, w);
    applyStimulus(4'd9, 8'hA5, 8'h08, w);
    waitDrain();

    // Wrap-around INC/DEC, carry-chained ADC, CMP and logic ops.
    for (int i = 0; i < 10; i++) begin
      applyStimulus(tblOp[i], tblA[i], tblB[i], w);
    end
    waitDrain();

    // Stall in DONE for 3 cycles, then take the result and accept a new op
    // on the same edge.
    out_ready = 1'b0;
    applyStimulus(4'd0, 8'h33, 8'h44, w);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("hold_valid", 32'(out_valid), 32'd1);
      checkOutput("hold_in_ready", 32'(in_ready), 32'd0);
      checkOutput("hold_result", 32'(result), 32'h77);
      checkOutput("hold_flags", 32'(flags), 32'b0000);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    applyStimulus(4'd6, 8'hF0, 8'h3C, w);
    checkOutput("b2b_waits", 32'(w), 32'd0);
    @(negedge clk);
    checkOutput("b2b_valid", 32'(out_valid), 32'd1);
    checkOutput("b2b_result", 32'(result), 32'hCC);
    @(posedge clk);
    #1;
    waitDrain();

    // Reset during a multiply after an op that left nonzero flags/result.
    applyStimulus(4'd3, 8'h00, 8'h00, w);
    waitDrain();
    applyStimulus(4'd13, 8'h0F, 8'h11, w);
    repeat (4) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("mrst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("mrst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("mrst_busy", 32'(busy), 32'd0);
    checkOutput("mrst_flags", 32'(flags), 32'd0);
    checkOutput("mrst_result", 32'(result), 32'd0);
    sbQ.delete();
    modelCarry = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    applyStimulus(4'd0, 8'h12, 8'h34, w);
    @(negedge clk);
    checkOutput("post_rst_valid", 32'(out_valid), 32'd1);
    checkOutput("post_rst_result", 32'(result), 32'h46);
    @(posedge clk);
    #1;
    waitDrain();

    // Random ops with a randomly stalling consumer.
    randReady = 1'b1;
    for (int i = 0; i < 40; i++) begin
      applyStimulus(4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom), w);
    end
    randReady = 1'b0;
    waitDrain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
